load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Sits between the single-cycle RV32I datapath and the synchronous data memory. It takes the effective address (ALU result), the store data (rs2) and funct3 from the datapath. It drives a req/gnt/rvalid handshake to data memory, with byte enables and lane-replicated write data. It returns sign- or zero-extended load data as RD_data and raises stall so the PC and register write are held until the access completes.

Parameters:
RESP_TIMEOUT, 255, max cycles waited in REQ or RESP before aborting with bus_err (1..65535)
CNT_W, 16, width of timeout counter; must hold RESP_TIMEOUT

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high; name and polarity as in the core
mem_read  in  1  current instruction is a load
mem_write  in  1  current instruction is a store
func  in  3  funct3 of current instruction
addr  in  32  effective address (alu_result)
wdata  in  32  store data (rs2 / mem_datain)
stall  out  1  hold PC and suppress reg_write this cycle
RD_data  out  32  extended load result, valid while state==DONE
misalign_err  out  1  one-cycle pulse: misaligned, illegal funct3, or read&write together
bus_err  out  1  one-cycle pulse: timeout expired
dm_req  out  1  memory request
dm_we  out  1  1=write, 0=read; valid with dm_req
dm_addr  out  32  word address, bits[1:0]=00
dm_be  out  4  byte enables
dm_wdata  out  32  write data, lane replicated
dm_gnt  in  1  memory accepted request this cycle
dm_rvalid  in  1  read data valid
dm_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE, counter=0. All outputs 0: stall, RD_data, errors, dm_req, dm_we, dm_addr, dm_be, dm_wdata. Reset mid-access abandons the transaction: dm_req drops the next edge, and a late dm_rvalid is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - stall = mem_read|mem_write (combinational).
  - If a request is legal, latch addr, be, wdata, func and dir, then go to REQ.
  - If illegal, go to DONE with misalign_err pulsed on entry; no memory access.
  - Illegal means any of: read&write both 1; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >010.
- REQ:
  - dm_req=1 and stall=1. dm_we/dm_addr/dm_be/dm_wdata come from registered values, stable until dm_gnt.
  - On dm_gnt, a store goes to DONE and a load goes to RESP.
- RESP: stall=1, dm_req=0. On dm_rvalid, capture the extended data into RD_data and go to DONE. dm_rvalid in any other state is ignored.
- Timeout: counter clears on entering REQ and increments each cycle in REQ or RESP. Reaching RESP_TIMEOUT goes to DONE with bus_err pulsed, RD_data=0, dm_req dropped.
- DONE: stall=0, so the datapath writes back and advances the PC at this edge. Always returns to IDLE, whatever the inputs. The error pulse is asserted only in the DONE cycle.
- Byte enables:
  - SB/LB/LBU: 0001<<addr[1:0].
  - SH/LH/LHU: 0011<<addr[1:0].
  - SW/LW: 1111.
- Write data: SB replicates the byte four times; SH replicates the halfword twice.
- Load extension: select the lane by latched addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend.
- RD_data holds its value until the next load capture or reset.
- Minimum latency: store 3 cycles (stall high 2); load 4 cycles with gnt in the first REQ cycle and rvalid on the next.

Decomposition:
- Shared package: funct3 load/store encodings (F3_B/H/W/BU/HU) and the state enum.
- One sub-module, lsu_align: combinational; produces dm_be, replicated wdata, the misalign flag and load extraction/extension. The FSM and counter stay in the top level.

Test Plan:
- SW addr=0x104 wdata=0xDEADBEEF, gnt in first REQ cycle -> dm_addr=0x104, dm_be=1111, dm_we=1, stall high 2 cycles, DONE in cycle 3.
- SB addr=0x0000_0013 wdata=0x000000A5 -> dm_be=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x10.
- LB addr=0x22, dm_rdata=0x80FF7F01, rvalid 1 cycle after gnt -> RD_data=0xFFFFFFFF. Repeat with LBU -> 0x000000FF. LH addr=0x22 -> 0xFFFF80FF.
- LW addr=0x102 -> no dm_req ever, misalign_err one pulse, stall high one cycle, DONE next. Also read&write both 1 -> same response.
- Load with dm_gnt withheld, RESP_TIMEOUT=4 -> bus_err pulse after 4 REQ cycles, RD_data=0, dm_req low, FSM back in IDLE.
- Reset asserted during RESP, then dm_rvalid arrives -> all outputs 0, state IDLE, RD_data stays 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 load/store widths and FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store-data replication, legality check,
// and extraction/extension of the returned load word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [2:0]  i_func,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  input  logic [2:0]  i_ld_func,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_bad;
  logic [31:0] w_lane;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    w_bad   = 1'b0;
    case (i_func)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        w_bad   = i_wr && (i_func == F3_BU);
      end
      F3_H, F3_HU: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
        w_bad   = i_off[0] || (i_wr && (i_func == F3_HU));
      end
      F3_W: begin
        o_be  = 4'b1111;
        w_bad = (i_off != 2'b00);
      end
      default: w_bad = 1'b1;
    endcase
    o_misalign = w_bad || (i_rd && i_wr);
  end

  // Shift the addressed lane down to bit 0 before extending.
  assign w_lane = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    case (i_ld_func)
      F3_B:    o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_BU:   o_ld_data = {24'h000000, w_lane[7:0]};
      F3_H:    o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_HU:   o_ld_data = {16'h0000, w_lane[15:0]};
      default: o_ld_data = w_lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sequences one data-memory access per load/store over a
// req/gnt/rvalid handshake and stalls the datapath until the access completes.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] RD_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RESP_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_func;
  logic [1:0]       r_off;
  logic             r_dm_req, r_dm_we, r_mis, r_bus;
  logic [31:0]      r_dm_addr, r_dm_wdata, r_rd_data;
  logic [3:0]       r_dm_be;

  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep, w_ld_data;
  logic             w_misalign;

  lsu_align u_align (
    .i_rd       (mem_read),
    .i_wr       (mem_write),
    .i_func     (func),
    .i_off      (addr[1:0]),
    .i_wdata    (wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_misalign (w_misalign),
    .i_ld_func  (r_func),
    .i_ld_off   (r_off),
    .i_rdata    (dm_rdata),
    .o_ld_data  (w_ld_data)
  );

  // In IDLE the stall must be combinational so the datapath holds in the issue cycle.
  assign stall = !reset && ((r_state == S_IDLE) ? (mem_read || mem_write)
                                                 : (r_state == S_REQ || r_state == S_RESP));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_func     <= 3'b000;
      r_off      <= 2'b00;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_be    <= 4'b0000;
      r_dm_wdata <= '0;
      r_rd_data  <= '0;
      r_mis      <= 1'b0;
      r_bus      <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      r_bus <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            if (w_misalign) begin
              r_mis   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dm_req   <= 1'b1;
              r_dm_we    <= mem_write;
              r_dm_addr  <= {addr[31:2], 2'b00};
              r_dm_be    <= w_be;
              r_dm_wdata <= w_wdata_rep;
              r_func     <= func;
              r_off      <= addr[1:0];
              r_cnt      <= '0;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dm_gnt) begin
            r_dm_req <= 1'b0;
            r_cnt    <= r_cnt + 1'b1;
            r_state  <= r_dm_we ? S_DONE : S_RESP;
          end else if (r_cnt >= TO_LAST) begin
            r_dm_req  <= 1'b0;
            r_bus     <= 1'b1;
            r_rd_data <= '0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (dm_rvalid) begin
            r_rd_data <= w_ld_data;
            r_state   <= S_DONE;
          end else if (r_cnt >= TO_LAST) begin
            r_bus     <= 1'b1;
            r_rd_data <= '0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RD_data      = r_rd_data;
  assign misalign_err = r_mis;
  assign bus_err      = r_bus;
  assign dm_req       = r_dm_req;
  assign dm_we        = r_dm_we;
  assign dm_addr      = r_dm_addr;
  assign dm_be        = r_dm_be;
  assign dm_wdata     = r_dm_wdata;

endmodule
